// File: rtl/clk_div_bank_if.sv
// Control/status bundle for clk_div_bank: per-channel run requests, divisor
// writes, and the registered divided-clock outputs.
interface clk_div_bank_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DIV_W = 25,
  parameter int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [N_CH-1:0]  en;
  logic             sync;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [DIV_W-1:0] wr_div;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  active;

  modport master (
    output en, sync, wr_en, wr_ch, wr_div,
    input  clk_out, tick, active
  );

  modport slave (
    input  en, sync, wr_en, wr_ch, wr_div,
    output clk_out, tick, active
  );
endinterface

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider. Each channel runs a glitch-free
// divided clock whose divisor, enable and sync only take effect at period starts.
module clk_div_bank #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned DIV_W   = 25,
  parameter int unsigned DIV_RST = 10000
) (
  input  logic           clk_in1,
  input  logic           rst,
  clk_div_bank_if.slave  bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

  state_e           state_q [N_CH];
  state_e           state_d [N_CH];
  logic [DIV_W-1:0] shadow_q [N_CH];
  logic [DIV_W-1:0] div_q    [N_CH];
  logic [DIV_W-1:0] div_d    [N_CH];
  logic [DIV_W-1:0] cnt_q    [N_CH];
  logic [DIV_W-1:0] cnt_d    [N_CH];
  logic [N_CH-1:0]  clk_out_q, clk_out_d;
  logic [N_CH-1:0]  tick_q, tick_d;
  logic [N_CH-1:0]  boundary_c, start_c;
  logic [DIV_W-1:0] wr_div_clamped_c;

  assign wr_div_clamped_c = (bus.wr_div < DIV_MIN) ? DIV_MIN : bus.wr_div;

  // Divisor staging; out-of-range channel selects match no entry.
  always_ff @(posedge clk_in1 or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) shadow_q[i] <= DIV_INIT;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.wr_en && (32'(bus.wr_ch) == i)) shadow_q[i] <= wr_div_clamped_c;
      end
    end
  end

  always_ff @(posedge clk_in1 or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
        div_q[i]   <= DIV_INIT;
        cnt_q[i]   <= '0;
      end
      clk_out_q <= '0;
      tick_q    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        div_q[i]   <= div_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  // Start action covers enable from idle, boundary with en held, and sync.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i]    = state_q[i];
      div_d[i]      = div_q[i];
      cnt_d[i]      = cnt_q[i];
      clk_out_d[i]  = clk_out_q[i];
      tick_d[i]     = 1'b0;
      boundary_c[i] = (state_q[i] == ST_RUN) && (cnt_q[i] == (div_q[i] - ONE));
      start_c[i]    = bus.en[i] && (bus.sync || (state_q[i] == ST_IDLE) || boundary_c[i]);

      if (start_c[i]) begin
        state_d[i]   = ST_RUN;
        div_d[i]     = shadow_q[i];
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b1;
        tick_d[i]    = 1'b1;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            cnt_d[i]     = '0;
            clk_out_d[i] = 1'b0;
          end
          ST_RUN: begin
            if (boundary_c[i]) begin
              state_d[i]   = ST_IDLE;
              cnt_d[i]     = '0;
              clk_out_d[i] = 1'b0;
            end else begin
              cnt_d[i]     = cnt_q[i] + ONE;
              clk_out_d[i] = (cnt_q[i] + ONE) < (div_q[i] >> 1);
            end
          end
          default: begin
            state_d[i]   = ST_IDLE;
            cnt_d[i]     = '0;
            clk_out_d[i] = 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_active
    assign bus.active[g] = (state_q[g] == ST_RUN);
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: constant vector table, directed corner
// sequences, and randomized traffic against a period-timestamp reference model.
module tb_clk_div_bank;

  logic clk_in1;
  logic rst;

  clk_div_bank_if #(.N_CH(4), .DIV_W(25)) bus ();
  clk_div_bank_if #(.N_CH(3), .DIV_W(8))  bus2 ();

  clk_div_bank #(.N_CH(4), .DIV_W(25), .DIV_RST(10000)) dut (
    .clk_in1 (clk_in1),
    .rst     (rst),
    .bus     (bus)
  );

  clk_div_bank #(.N_CH(3), .DIV_W(8), .DIV_RST(5)) dut2 (
    .clk_in1 (clk_in1),
    .rst     (rst),
    .bus     (bus2)
  );

  initial clk_in1 = 1'b0;
  always #5 clk_in1 = ~clk_in1;

  int n_pass;
  int n_total;

  // Reference model: each running channel remembers the cycle its period began.
  int unsigned k;
  bit          m_run    [4];
  int unsigned m_d      [4];
  int unsigned m_start  [4];
  int unsigned m_shadow [4];

  typedef struct {
    logic [3:0]  en;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [24:0] wr_div;
    logic [3:0]  clk;
    logic [3:0]  tick;
    logic [3:0]  act;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, k);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_run[i]    = 1'b0;
      m_d[i]      = 10000;
      m_start[i]  = 0;
      m_shadow[i] = 10000;
    end
  endfunction

  function automatic void model_edge();
    bit at_end;
    for (int i = 0; i < 4; i++) begin
      at_end = m_run[i] && ((k - m_start[i]) == (m_d[i] - 1));
      if (bus.en[i] && (!m_run[i] || bus.sync || at_end)) begin
        m_run[i]   = 1'b1;
        m_d[i]     = m_shadow[i];
        m_start[i] = k + 1;
      end else if (at_end) begin
        m_run[i] = 1'b0;
      end
    end
    if (bus.wr_en) m_shadow[bus.wr_ch] = (bus.wr_div < 25'd2) ? 2 : int'(bus.wr_div);
    k++;
  endfunction

  task automatic check_model();
    logic [3:0] ec, et, ea;
    for (int i = 0; i < 4; i++) begin
      ea[i] = m_run[i];
      et[i] = m_run[i] && (k == m_start[i]);
      ec[i] = m_run[i] && ((k - m_start[i]) < (m_d[i] / 2));
    end
    chk("model_clk_out", 32'(bus.clk_out), 32'(ec));
    chk("model_tick",    32'(bus.tick),    32'(et));
    chk("model_active",  32'(bus.active),  32'(ea));
  endtask

  task automatic step();
    @(posedge clk_in1);
    if (!rst) model_reset();
    else model_edge();
    @(negedge clk_in1);
    check_model();
  endtask

  task automatic wr(input logic [1:0] ch, input logic [24:0] div);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = ch;
    bus.wr_div = div;
    step();
    bus.wr_en  = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    bus.en   = '0;
    bus.sync = 1'b0;
    for (int s = 0; s < max_cycles && bus.active != 4'b0000; s++) step();
    chk("drain_idle", 32'(bus.active), 32'd0);
  endtask

  initial begin
    int hi, t1, t2, other;
    logic [26:0] pat, tpat;

    n_pass = 0; n_total = 0; k = 0;
    rst = 1'b0;
    bus.en = '0; bus.sync = 1'b0; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_div = '0;
    bus2.en = '0; bus2.sync = 1'b0; bus2.wr_en = 1'b0; bus2.wr_ch = '0; bus2.wr_div = '0;
    model_reset();

    tbl[0]  = '{4'b0000, 1'b1, 2'd1, 25'd3, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0010, 1'b0, 2'd0, 25'd0, 4'b0010, 4'b0010, 4'b0010};
    tbl[2]  = '{4'b0010, 1'b0, 2'd0, 25'd0, 4'b0000, 4'b0000, 4'b0010};
    tbl[3]  = '{4'b0010, 1'b0, 2'd0, 25'd0, 4'b0000, 4'b0000, 4'b0010};
    tbl[4]  = '{4'b0010, 1'b0, 2'd0, 25'd0, 4'b0010, 4'b0010, 4'b0010};
    tbl[5]  = '{4'b0010, 1'b1, 2'd1, 25'd0, 4'b0000, 4'b0000, 4'b0010};
    tbl[6]  = '{4'b0010, 1'b0, 2'd0, 25'd0, 4'b0000, 4'b0000, 4'b0010};
    tbl[7]  = '{4'b0010, 1'b0, 2'd0, 25'd0, 4'b0010, 4'b0010, 4'b0010};
    tbl[8]  = '{4'b0010, 1'b0, 2'd0, 25'd0, 4'b0000, 4'b0000, 4'b0010};
    tbl[9]  = '{4'b0010, 1'b0, 2'd0, 25'd0, 4'b0010, 4'b0010, 4'b0010};
    tbl[10] = '{4'b0000, 1'b0, 2'd0, 25'd0, 4'b0000, 4'b0000, 4'b0010};
    tbl[11] = '{4'b0000, 1'b0, 2'd0, 25'd0, 4'b0000, 4'b0000, 4'b0000};

    repeat (2) @(negedge clk_in1);
    chk("reset_clk_out", 32'(bus.clk_out), 32'd0);
    chk("reset_tick",    32'(bus.tick),    32'd0);
    chk("reset_active",  32'(bus.active),  32'd0);
    rst = 1'b1;
    step();

    // D=3 then clamped D=2 on channel 1, then disable.
    for (int v = 0; v < 12; v++) begin
      bus.en     = tbl[v].en;
      bus.wr_en  = tbl[v].wr_en;
      bus.wr_ch  = tbl[v].wr_ch;
      bus.wr_div = tbl[v].wr_div;
      step();
      chk($sformatf("tbl%0d_clk", v),  32'(bus.clk_out), 32'(tbl[v].clk));
      chk($sformatf("tbl%0d_tick", v), 32'(bus.tick),    32'(tbl[v].tick));
      chk($sformatf("tbl%0d_act", v),  32'(bus.active),  32'(tbl[v].act));
    end
    bus.wr_en = 1'b0;

    // Channel 0 at the reset divisor.
    bus.en = 4'b0001;
    hi = 0; t1 = -1; t2 = -1; other = 0;
    for (int s = 1; s <= 10001; s++) begin
      step();
      if (s <= 10000 && bus.clk_out[0]) hi++;
      if (bus.tick[0]) begin
        if (t1 < 0) t1 = s;
        else if (t2 < 0) t2 = s;
      end
      if (bus.clk_out[3:1] != 3'b000) other++;
    end
    chk("ch0_high_cycles", 32'(hi), 32'd5000);
    chk("ch0_first_tick", 32'(t1), 32'd1);
    chk("ch0_tick_period", 32'(t2 - t1), 32'd10000);
    chk("ch0_others_quiet", 32'(other), 32'd0);
    drain(10001);

    // Channel 2: mid-period write 8->4, then a write on the boundary cycle 4->6.
    wr(2'd2, 25'd8);
    bus.en = 4'b0100;
    for (int s = 1; s <= 27; s++) begin
      bus.wr_en  = (s == 3) || (s == 17);
      bus.wr_ch  = 2'd2;
      bus.wr_div = (s == 3) ? 25'd4 : 25'd6;
      step();
      pat[27 - s]  = bus.clk_out[2];
      tpat[27 - s] = bus.tick[2];
    end
    bus.wr_en = 1'b0;
    chk("ch2_clk_pattern",  32'(pat),  32'(27'b111100001100110011001110001));
    chk("ch2_tick_pattern", 32'(tpat), 32'(27'b100000001000100010001000001));
    drain(10);

    // Sync aligns channels running at D=5,6,7,8.
    wr(2'd0, 25'd5); wr(2'd1, 25'd6); wr(2'd2, 25'd7); wr(2'd3, 25'd8);
    bus.en = 4'b1111;
    repeat (7) step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    chk("sync_clk",  32'(bus.clk_out), 32'(4'b1111));
    chk("sync_tick", 32'(bus.tick),    32'(4'b1111));
    step();
    chk("sync_p1_clk",  32'(bus.clk_out), 32'(4'b1111));
    chk("sync_p1_tick", 32'(bus.tick),    32'(4'b0000));
    step();
    chk("sync_p2_clk", 32'(bus.clk_out), 32'(4'b1110));
    drain(20);

    // Drop en[0] two cycles into a D=10 period.
    wr(2'd0, 25'd10);
    bus.en = 4'b0001;
    hi = 0;
    for (int s = 1; s <= 10; s++) begin
      if (s == 4) bus.en = 4'b0000;
      step();
      if (bus.clk_out[0]) hi++;
    end
    chk("drop_high_cycles", 32'(hi), 32'd5);
    chk("drop_still_active", 32'(bus.active[0]), 32'd1);
    step();
    chk("drop_clk_low", 32'(bus.clk_out[0]), 32'd0);
    chk("drop_inactive", 32'(bus.active[0]), 32'd0);
    bus.en = 4'b0001;
    step();
    chk("reenable_clk",  32'(bus.clk_out[0]), 32'd1);
    chk("reenable_tick", 32'(bus.tick[0]),    32'd1);
    drain(20);

    // Randomized traffic with small divisors.
    for (int s = 0; s < 3000; s++) begin
      if ($urandom_range(0, 7) == 0) bus.en = 4'($urandom);
      bus.sync   = ($urandom_range(0, 15) == 0);
      bus.wr_en  = ($urandom_range(0, 3) == 0);
      bus.wr_ch  = 2'($urandom);
      bus.wr_div = 25'($urandom_range(0, 12));
      step();
    end
    bus.wr_en = 1'b0;
    drain(20);

    // Asynchronous reset mid-period discards a written divisor.
    wr(2'd0, 25'd6);
    bus.en = 4'b0001;
    repeat (3) step();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_clk",    32'(bus.clk_out), 32'd0);
    chk("async_rst_tick",   32'(bus.tick),    32'd0);
    chk("async_rst_active", 32'(bus.active),  32'd0);
    step();
    step();
    rst = 1'b1;
    t1 = -1; t2 = -1;
    for (int s = 1; s <= 10001; s++) begin
      step();
      if (bus.tick[0]) begin
        if (t1 < 0) t1 = s;
        else if (t2 < 0) t2 = s;
      end
    end
    chk("post_rst_first_tick", 32'(t1), 32'd1);
    chk("post_rst_period", 32'(t2 - t1), 32'd10000);
    drain(10001);

    // Out-of-range channel write on a 3-channel instance.
    bus2.wr_en  = 1'b1;
    bus2.wr_ch  = 2'd3;
    bus2.wr_div = 8'd2;
    step();
    bus2.wr_en = 1'b0;
    bus2.en    = 3'b111;
    for (int s = 1; s <= 10; s++) begin
      step();
      chk($sformatf("oor_clk%0d", s), 32'(bus2.clk_out),
          (((s - 1) % 5) < 2) ? 32'd7 : 32'd0);
      chk($sformatf("oor_tick%0d", s), 32'(bus2.tick),
          (((s - 1) % 5) == 0) ? 32'd7 : 32'd0);
    end
    bus2.en = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
